imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

- Buffered, parametrised RV32/RV64 immediate-generation stage between fetch and decode.
- Accepts instruction words over a valid/ready handshake and classifies each word by immediate format.
- Produces the XLEN-wide immediate, a format code and an illegal flag, queued in a DEPTH-entry FIFO.
- Decode consumes the results at its own pace; a flush input empties the stage on redirects.

## Interface
- XLEN, 32: datapath width, 32 or 64; selects RV32I or RV64I immediate/shamt rules.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- clk  in  1  clock, rising-edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- flush  in  1  synchronous clear of all entries; has priority over push.
- in_valid  in  1  in_inst is presented.
- in_ready  out  1  stage can accept; equals !full and does not depend on out_ready.
- in_inst  in  32  instruction word.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes head this cycle.
- out_imm  out  XLEN  immediate of head entry.
- out_fmt  out  3  0 R/none, 1 U, 2 J, 3 I, 4 B, 5 S, 6 SH, 7 Z.
- out_illegal  out  1  head word is not a recognised encoding.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Classification uses opcode inst[6:0] and funct3 inst[14:12]:
  - LUI 0110111 and AUIPC 0010111 → U: sext({inst[31:12],12'b0}) to XLEN.
  - JAL 1101111 → J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - JALR 1100111 → I; legal only with funct3=000.
  - LOAD 0000011 → I; legal funct3 000/001/010/100/101, plus 011/110 when XLEN=64.
  - OP-IMM 0010011 with funct3 ≠ 001/101 → I: sext(inst[31:20]).
  - BRANCH 1100011 → B; funct3 010/011 illegal. Immediate is sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - STORE 0100011 → S; legal funct3 000/001/010, plus 011 when XLEN=64. Immediate is sext({inst[31:25],inst[11:7]}).
- Shift immediates (OP-IMM funct3 001/101) → SH:
  - Immediate is the shamt, zero-extended and never sign-extended.
  - XLEN=32: shamt inst[24:20]; inst[25] must be 0.
  - XLEN=64: shamt inst[25:20].
  - inst[31:26] must be 000000; 010000 is allowed only for funct3=101 (srai). Any other value is illegal.
- OP 0110011 → R with imm 0; legal only for the ten RV32I funct7/funct3 combinations.
- Any other opcode, or an illegal field combination, gives fmt 0, imm 0, illegal=1.
- Immediate computation is combinational on in_inst. The result is written into the FIFO at the push edge, so out_* are always register outputs.
- FIFO:
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready && !flush.
  - A simultaneous push and pop keeps count unchanged. Read/write pointers wrap modulo DEPTH.
  - When full, in_ready is 0 and in_valid is ignored, even if a pop occurs that cycle.
- flush sets count=0 and pointers to 0 at the next edge. Any same-cycle push or pop is discarded.

## Timing
- Reset, asynchronous on rstn low: count=0, pointers=0, out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0.
- Latency: a word accepted at edge N appears at out_* with out_valid=1 from edge N (visible in cycle N+1) when the FIFO was empty.
- Throughput: one word per cycle when out_ready stays high.
- Head data stays stable while out_valid && !out_ready.
- Reset asserted mid-stream discards all entries immediately. The first push after rstn deasserts follows the normal latency.

## Configuration
- IMM_GEN_CSR_EN defined: SYSTEM 1110011 with funct3 101/110/111 → Z, imm zero-extended inst[19:15]. Funct3 001/010/011 → fmt 0, legal.
- IMM_GEN_CSR_EN undefined: every SYSTEM opcode is illegal with fmt 0, and fmt code 7 is never produced.

## Test plan
- XLEN=32, push 0xFFF00093 (addi -1) → out_imm 0xFFFFFFFF, fmt 3, illegal 0, one cycle after acceptance.
- Push 0x123450B7, 0xFFDFF06F, 0x00000463, 0xFE112C23 back-to-back with out_ready=1:
  - Outputs in order: 0x12345000/1, 0xFFFFFFFC/2, 0x00000008/4, 0xFFFFFFF8/5.
  - Required rate: one result per cycle.
- Push 0x4030D093 (srai 3) → imm 3, fmt 6.
  - 0x0230D093 (inst[25]=1) at XLEN=32 → illegal 1, imm 0.
  - At XLEN=64 the same word → imm 35, legal.
- DEPTH=2, out_ready=0, in_valid held with three words:
  - in_ready falls after two accepts and count=2.
  - The third word is held until out_ready=1.
  - Outputs appear in FIFO order, and no word is lost or duplicated.
- count=2, assert flush together with in_valid and out_ready → count=0 and out_valid=0 next cycle, and the pushed word is discarded.
- Drop rstn asynchronously between edges while count=1 → out_valid 0 and count 0 before the next clock edge.
- With IMM_GEN_CSR_EN: 0x3400D073 → fmt 7, imm 1. Without IMM_GEN_CSR_EN the same word → illegal 1.

Source files
------------

// File: rtl/imm_gen_stage.sv
// Buffered RV32/RV64 immediate-generation stage: classifies each instruction word and queues its
// immediate, format code and illegal flag in a DEPTH-entry FIFO. Optional feature macro: IMM_GEN_CSR_EN.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_imm,
  output logic [2:0]               out_fmt,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_U  = 3'd1,
    FMT_J  = 3'd2,
    FMT_I  = 3'd3,
    FMT_B  = 3'd4,
    FMT_S  = 3'd5,
    FMT_SH = 3'd6,
    FMT_Z  = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [31:0]     immI;
  logic [31:0]     immS;
  logic [31:0]     immB;
  logic [31:0]     immJ;
  fmt_e            decFmt;
  logic [XLEN-1:0] decImm;
  logic            decIll;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign funct7 = in_inst[31:25];
  assign immI   = {{20{in_inst[31]}}, in_inst[31:20]};
  assign immS   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign immB   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign immJ   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  // Classification; any illegal combination collapses to fmt 0 / imm 0 at the end.
  always_comb begin
    decFmt = FMT_R;
    decImm = '0;
    decIll = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        decFmt = FMT_U;
        decImm = sext32({in_inst[31:12], 12'b0});
      end
      OPC_JAL: begin
        decFmt = FMT_J;
        decImm = sext32(immJ);
      end
      OPC_JALR: begin
        decFmt = FMT_I;
        decImm = sext32(immI);
        decIll = (funct3 != 3'b000);
      end
      OPC_LOAD: begin
        decFmt = FMT_I;
        decImm = sext32(immI);
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: decIll = 1'b0;
          3'b011, 3'b110:                         decIll = (XLEN != 64);
          default:                                decIll = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          // Shift amounts are zero-extended; RV32 reserves inst[25].
          decFmt = FMT_SH;
          if (XLEN == 64) begin
            decImm = XLEN'(in_inst[25:20]);
          end else begin
            decImm = XLEN'(in_inst[24:20]);
            decIll = in_inst[25];
          end
          if (in_inst[31:26] == 6'b000000) begin
            decIll = decIll;
          end else if (in_inst[31:26] == 6'b010000 && funct3 == 3'b101) begin
            decIll = decIll;
          end else begin
            decIll = 1'b1;
          end
        end else begin
          decFmt = FMT_I;
          decImm = sext32(immI);
        end
      end
      OPC_BRANCH: begin
        decFmt = FMT_B;
        decImm = sext32(immB);
        decIll = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_STORE: begin
        decFmt = FMT_S;
        decImm = sext32(immS);
        case (funct3)
          3'b000, 3'b001, 3'b010: decIll = 1'b0;
          3'b011:                 decIll = (XLEN != 64);
          default:                decIll = 1'b1;
        endcase
      end
      OPC_OP: begin
        decFmt = FMT_R;
        decIll = !((funct7 == 7'b0000000) ||
                   (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
      end
`ifdef IMM_GEN_CSR_EN
      OPC_SYSTEM: begin
        case (funct3)
          3'b101, 3'b110, 3'b111: begin
            decFmt = FMT_Z;
            decImm = XLEN'(in_inst[19:15]);
          end
          3'b001, 3'b010, 3'b011: decFmt = FMT_R;
          default:                decIll = 1'b1;
        endcase
      end
`else
      OPC_SYSTEM: decIll = 1'b1;
`endif
      default: decIll = 1'b1;
    endcase
    if (decIll) begin
      decFmt = FMT_R;
      decImm = '0;
    end
  end

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  entry_t        head;
  entry_t        decEntry;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && out_ready && !flush;
  assign decEntry = '{imm: decImm, fmt: decFmt, ill: decIll};

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + AW'(1);
      if (pop)  rdPtr_d = rdPtr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) mem_q[wrPtr_q] <= decEntry;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  assign head        = mem_q[rdPtr_q];
  assign in_ready    = !full;
  assign out_valid   = !empty;
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.ill;
  assign count       = count_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Self-checking bench for imm_gen_stage: an RV32 and an RV64 instance share one stimulus stream.
module tb_imm_gen_stage;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic        out_ready;

  logic        inReady32, outValid32, outIll32;
  logic [31:0] outImm32;
  logic [2:0]  outFmt32;
  logic [1:0]  count32;

  logic        inReady64, outValid64, outIll64;
  logic [63:0] outImm64;
  logic [2:0]  outFmt64;
  logic [1:0]  count64;

  int checks;
  int failures;

  imm_gen_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(inReady32),
    .in_inst(in_inst), .out_valid(outValid32), .out_ready(out_ready), .out_imm(outImm32),
    .out_fmt(outFmt32), .out_illegal(outIll32), .count(count32)
  );

  imm_gen_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(inReady64),
    .in_inst(in_inst), .out_valid(outValid64), .out_ready(out_ready), .out_imm(outImm64),
    .out_fmt(outFmt64), .out_illegal(outIll64), .count(count64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic        ill32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic        ill64;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Single word pushed into an empty FIFO, checked one cycle later, then popped.
  task automatic applyStimulus(input int idx, input vec_t v);
    in_inst   = v.inst;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    stepClock();
    in_valid = 1'b0;
    checkOutput($sformatf("v%0d valid32", idx), 64'(outValid32), 64'd1);
    checkOutput($sformatf("v%0d imm32", idx), 64'(outImm32), 64'(v.imm32));
    checkOutput($sformatf("v%0d fmt32", idx), 64'(outFmt32), 64'(v.fmt32));
    checkOutput($sformatf("v%0d ill32", idx), 64'(outIll32), 64'(v.ill32));
    checkOutput($sformatf("v%0d imm64", idx), outImm64, v.imm64);
    checkOutput($sformatf("v%0d fmt64", idx), 64'(outFmt64), 64'(v.fmt64));
    checkOutput($sformatf("v%0d ill64", idx), 64'(outIll64), 64'(v.ill64));
    out_ready = 1'b1;
    stepClock();
    out_ready = 1'b0;
    checkOutput($sformatf("v%0d drained", idx), 64'(count32), 64'd0);
  endtask

  logic [31:0] tpInst [4];
  logic [31:0] tpImm  [4];
  logic [2:0]  tpFmt  [4];

  initial begin
    checks    = 0;
    failures  = 0;
    rstn      = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = 32'h0;
    out_ready = 1'b0;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd3, 1'b0};
    vecs[1]  = '{32'h123450B7, 32'h12345000, 3'd1, 1'b0, 64'h0000000012345000, 3'd1, 1'b0};
    vecs[2]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    vecs[3]  = '{32'h00000463, 32'h00000008, 3'd4, 1'b0, 64'h0000000000000008, 3'd4, 1'b0};
    vecs[4]  = '{32'hFE112C23, 32'hFFFFFFF8, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFF8, 3'd5, 1'b0};
    vecs[5]  = '{32'h4030D093, 32'h00000003, 3'd6, 1'b0, 64'h0000000000000003, 3'd6, 1'b0};
    vecs[6]  = '{32'h0230D093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000023, 3'd6, 1'b0};
    vecs[7]  = '{32'h00003003, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd3, 1'b0};
    vecs[8]  = '{32'h40000033, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    vecs[9]  = '{32'h40001033, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[10] = '{32'h00002063, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[11] = '{32'h00001067, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[12] = '{32'h00400067, 32'h00000004, 3'd3, 1'b0, 64'h0000000000000004, 3'd3, 1'b0};
    vecs[13] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    vecs[14] = '{32'h40001093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
`ifdef IMM_GEN_CSR_EN
    vecs[15] = '{32'h3400D073, 32'h00000001, 3'd7, 1'b0, 64'h0000000000000001, 3'd7, 1'b0};
`else
    vecs[15] = '{32'h3400D073, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
`endif
    vecs[16] = '{32'h800000B7, 32'h80000000, 3'd1, 1'b0, 64'hFFFFFFFF80000000, 3'd1, 1'b0};
    vecs[17] = '{32'h00003023, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd5, 1'b0};

    tpInst = '{32'h123450B7, 32'hFFDFF06F, 32'h00000463, 32'hFE112C23};
    tpImm  = '{32'h12345000, 32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFF8};
    tpFmt  = '{3'd1, 3'd2, 3'd4, 3'd5};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset valid", 64'(outValid32), 64'd0);
    checkOutput("reset ready", 64'(inReady32), 64'd1);
    checkOutput("reset count", 64'(count32), 64'd0);
    checkOutput("reset imm", 64'(outImm32), 64'd0);
    checkOutput("reset fmt", 64'(outFmt32), 64'd0);
    checkOutput("reset ill", 64'(outIll32), 64'd0);
    rstn = 1'b1;
    stepClock();

    for (int i = 0; i < 18; i++) applyStimulus(i, vecs[i]);

    // Back-to-back pushes with the consumer always ready.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_inst = tpInst[i];
      stepClock();
      checkOutput($sformatf("tp%0d valid", i), 64'(outValid32), 64'd1);
      checkOutput($sformatf("tp%0d imm", i), 64'(outImm32), 64'(tpImm[i]));
      checkOutput($sformatf("tp%0d fmt", i), 64'(outFmt32), 64'(tpFmt[i]));
      checkOutput($sformatf("tp%0d count", i), 64'(count32), 64'd1);
    end
    in_valid = 1'b0;
    stepClock();
    checkOutput("tp drained", 64'(outValid32), 64'd0);

    // Fill to DEPTH with the consumer stalled; third word must wait.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    stepClock();
    checkOutput("full c1 count", 64'(count32), 64'd1);
    checkOutput("full c1 ready", 64'(inReady32), 64'd1);
    in_inst = 32'h123450B7;
    stepClock();
    checkOutput("full c2 count", 64'(count32), 64'd2);
    checkOutput("full c2 ready", 64'(inReady32), 64'd0);
    in_inst = 32'hFFDFF06F;
    stepClock();
    checkOutput("full c3 count", 64'(count32), 64'd2);
    checkOutput("full c3 head", 64'(outImm32), 64'hFFFFFFFF);
    out_ready = 1'b1;
    stepClock();
    checkOutput("full c4 count", 64'(count32), 64'd1);
    checkOutput("full c4 head", 64'(outImm32), 64'h12345000);
    checkOutput("full c4 ready", 64'(inReady32), 64'd1);
    stepClock();
    checkOutput("full c5 count", 64'(count32), 64'd1);
    checkOutput("full c5 head", 64'(outImm32), 64'hFFFFFFFC);
    checkOutput("full c5 fmt", 64'(outFmt32), 64'd2);
    in_valid = 1'b0;
    stepClock();
    checkOutput("full c6 count", 64'(count32), 64'd0);
    checkOutput("full c6 valid", 64'(outValid32), 64'd0);

    // Flush while full, with push and pop requested in the same cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    stepClock();
    in_inst = 32'h123450B7;
    stepClock();
    checkOutput("flush pre count", 64'(count32), 64'd2);
    flush     = 1'b1;
    in_inst   = 32'hFFDFF06F;
    out_ready = 1'b1;
    stepClock();
    flush = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush full count", 64'(count32), 64'd0);
    checkOutput("flush full valid", 64'(outValid32), 64'd0);

    // Flush at count=1 with an acceptable push: the push must be discarded.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'hFFF00093;
    stepClock();
    flush     = 1'b1;
    in_inst   = 32'h123450B7;
    out_ready = 1'b1;
    stepClock();
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush one count", 64'(count32), 64'd0);
    checkOutput("flush one valid", 64'(outValid32), 64'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00000463;
    stepClock();
    in_valid = 1'b0;
    checkOutput("post flush head", 64'(outImm32), 64'h8);
    checkOutput("post flush count", 64'(count32), 64'd1);

    // Asynchronous reset between edges with one entry held.
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("arst valid", 64'(outValid32), 64'd0);
    checkOutput("arst count", 64'(count32), 64'd0);
    checkOutput("arst imm", 64'(outImm32), 64'd0);
    checkOutput("arst ready", 64'(inReady32), 64'd1);
    checkOutput("arst count64", 64'(count64), 64'd0);
    stepClock();
    rstn = 1'b1;
    stepClock();
    in_valid = 1'b1;
    in_inst  = 32'hFE112C23;
    stepClock();
    in_valid = 1'b0;
    checkOutput("post rst valid", 64'(outValid32), 64'd1);
    checkOutput("post rst imm", 64'(outImm32), 64'hFFFFFFF8);
    out_ready = 1'b1;
    stepClock();
    checkOutput("post rst drained", 64'(count32), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
